// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid port plus the
// decode-facing instr/pc/valid, stall and redirect signals.
`timescale 1ns/1ps
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;

  modport master (
    output imem_req, imem_addr, instr_out, pc_out, valid_out,
    input  imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pc_out, valid_out,
    output imem_gnt, imem_rvalid, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front-end: owns the PC, issues sequential word fetches,
// buffers returned words with their PC and hands them to decode.
`timescale 1ns/1ps
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = CW + 2;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] outst_q,    outst_d;
  logic [CW-1:0] kill_q,     kill_d;
  logic [CW-1:0] count_q,    count_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;

  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   fifo_instr [FIFO_DEPTH];

  logic          empty, valid, pop, req, issue, resp, kill_hit, push;
  logic [UW-1:0] used;
  logic [CW-1:0] inflight;

  always_comb begin
    empty = (count_q == '0);
    valid = !rst && !bus.redirect && !empty;
    pop   = valid && !bus.stall;
    // An entry leaving this cycle frees its slot for a new request, which is
    // what keeps a single-cycle memory streaming without bubbles.
    used  = UW'(count_q) + UW'(outst_q) + UW'(kill_q) - UW'(pop);
    req   = !rst && !bus.redirect && (used < UW'(FIFO_DEPTH));
    issue = req && bus.imem_gnt;
    resp     = bus.imem_rvalid && !bus.redirect;
    kill_hit = resp && (kill_q != '0);
    push     = resp && (kill_q == '0) && (outst_q != '0);
    inflight = kill_q + outst_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    kill_d     = kill_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      resp_pc_d  = {bus.redirect_pc[31:2], 2'b00};
      outst_d    = '0;
      // A word returning in the redirect cycle already settles one in-flight slot.
      kill_d     = inflight - CW'(bus.imem_rvalid && (inflight != '0));
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CW'(issue) - CW'(push);
      kill_d  = kill_q - CW'(kill_hit);
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      kill_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      kill_q     <= kill_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc[wr_ptr_q]    <= resp_pc_q;
      fifo_instr[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.valid_out = valid;
  assign bus.instr_out = empty ? 32'h0 : fifo_instr[rd_ptr_q];
  assign bus.pc_out    = empty ? 32'h0 : fifo_pc[rd_ptr_q];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queued instruction-memory model returning
// addr>>2 as data, plus an in-order scoreboard of expected {pc, instr} pairs.
`timescale 1ns/1ps
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int issues = 0;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  exp_t sb[$];

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  mreq_t rv;
  int  cyc = 0;
  int  lat = 1;
  logic hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_start(input logic [31:0] pc0, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = pc0 + 32'(4 * i);
      sb.push_back('{pc: p, ins: p >> 2});
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instruction memory: in-order responses, each no earlier than lat cycles after grant.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= 32'h0;
    end else begin
      if (bus.imem_req && bus.imem_gnt) mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
      if (!hold && mq.size() > 0 && mq[0].due <= cyc + 1) begin
        rv = mq.pop_front();
        bus.imem_rvalid <= 1'b1;
        bus.imem_rdata  <= rv.addr >> 2;
      end else begin
        bus.imem_rvalid <= 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  // Decode-side scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (!rst && bus.valid_out && !bus.stall) begin
      out_cnt++;
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", bus.pc_out, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", bus.pc_out, e.pc);
        chk("sb_instr", bus.instr_out, e.ins);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [31:0] a0;
    rst = 1'b1;
    bus.imem_gnt    = 1'b1;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    step(3);

    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc_out", bus.pc_out, 32'h0);

    // Stream from reset: valid from cycle 2, no bubbles.
    sb_start(32'h0, 200);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("start_valid_c%0d", c), {31'b0, bus.valid_out}, (c >= 2) ? 32'd1 : 32'd0);
      step(1);
    end

    // Stall with the head at 0x8.
    bus.stall = 1'b1;
    issues = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_valid_c%0d", c), {31'b0, bus.valid_out}, 32'd1);
      chk($sformatf("stall_head_c%0d", c), bus.pc_out, 32'h8);
      if (bus.imem_req && bus.imem_gnt) issues++;
      step(1);
    end
    chk("stall_issue_bound", 32'(issues <= 2), 32'd1);
    bus.stall = 1'b0;
    base = out_cnt;
    step(10);
    chk("stall_release_rate", 32'(out_cnt - base), 32'd10);

    // Redirect with two fetches held in flight.
    hold = 1'b1;
    step(6);
    @(negedge clk);
    chk("hold_drained_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("hold_no_credit", {31'b0, bus.imem_req}, 32'd0);
    step(1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    sb_start(32'h100, 200);
    @(negedge clk);
    chk("redir_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("redir_req", {31'b0, bus.imem_req}, 32'd0);
    step(1);
    bus.redirect = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("redir_addr", bus.imem_addr, 32'h100);
    base = out_cnt;
    step(10);
    chk("redir_progress", 32'(out_cnt - base > 4), 32'd1);

    // Grant withheld: request and address held, output drains.
    bus.imem_gnt = 1'b0;
    @(negedge clk);
    a0 = bus.imem_addr;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("nognt_req_c%0d", c), {31'b0, bus.imem_req}, 32'd1);
      chk($sformatf("nognt_addr_c%0d", c), bus.imem_addr, a0);
      if (c == 3) chk("nognt_drained", {31'b0, bus.valid_out}, 32'd0);
      step(1);
    end
    bus.imem_gnt = 1'b1;
    step(8);

    // Redirect coinciding with the single outstanding response.
    chk("coinc_rvalid", {31'b0, bus.imem_rvalid}, 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    sb_start(32'h200, 200);
    step(1);
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("coinc_req", {31'b0, bus.imem_req}, 32'd1);
    chk("coinc_addr", bus.imem_addr, 32'h200);
    step(6);

    // Back-to-back redirects: the second one defines the PC.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0300;
    sb_start(32'h404, 200);
    step(1);
    bus.redirect_pc = 32'h0000_0406;
    step(1);
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("b2b_addr", bus.imem_addr, 32'h404);
    base = out_cnt;
    step(8);
    chk("b2b_progress", 32'(out_cnt - base >= 4), 32'd1);

    // PC wrap at the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFF8;
    sb_start(32'hFFFF_FFF8, 200);
    step(1);
    bus.redirect = 1'b0;
    base = out_cnt;
    step(8);
    chk("wrap_progress", 32'(out_cnt - base >= 4), 32'd1);

    // Reset mid-stream with the buffer full.
    bus.stall = 1'b1;
    step(4);
    @(negedge clk);
    chk("full_valid", {31'b0, bus.valid_out}, 32'd1);
    step(1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_valid", {31'b0, bus.valid_out}, 32'd0);
    chk("midrst_req", {31'b0, bus.imem_req}, 32'd0);
    step(1);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_valid_next", {31'b0, bus.valid_out}, 32'd0);
    sb_start(32'h0, 200);
    rst = 1'b0;
    bus.stall = 1'b0;
    base = out_cnt;
    step(6);
    chk("postrst_progress", 32'(out_cnt - base >= 3), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
